// File: rtl/core_run_ctrl.sv
// core_run_ctrl
//   Run controller for the single-cycle RV32 core. Sequences the core's
//   reset, bounds the run length and watches the fetch stream for halt
//   conditions (ebreak, ecall, self-loop, cycle timeout). All outputs are
//   registered.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset of this block
//   start         one-cycle pulse beginning a run (honoured in IDLE/DONE)
//   pc            current PC of the core
//   instr         current fetched instruction
//   instr_valid   pc/instr valid this cycle (sampled in RUN only)
//   core_rst      active-high reset driven to the core
//   run_active    high while the core is running
//   done          sticky run-complete flag
//   timeout       sticky: run ended by reaching MAX_CYCLES
//   halt_cause    0 none, 1 ebreak, 2 ecall, 3 self-loop
//   cycle_count   cycles spent in RUN (saturating)
//   retired_count RUN cycles with instr_valid high (saturating)

module core_run_ctrl #(
  parameter int XLEN        = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 7,
  parameter int LOOP_DETECT = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             core_rst,
  output logic             run_active,
  output logic             done,
  output logic             timeout,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam int          HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET_HOLD,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [XLEN-1:0]   last_pc, last_pc_next;
  logic [31:0]       loop_len, loop_len_next;
  logic              loop_seen, loop_seen_next;
  logic              done_next, timeout_next;
  logic [1:0]        cause_next;
  logic [CNT_W-1:0]  cycle_next, retired_next;

  // Scratch values for the RUN-state halt evaluation.
  logic [CNT_W-1:0]  cycle_inc;
  logic [31:0]       run_len;
  logic              loop_hit;

  // State and all registered outputs. core_rst/run_active follow the
  // next state so they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      last_pc       <= '0;
      loop_len      <= '0;
      loop_seen     <= 1'b0;
      core_rst      <= 1'b1;
      run_active    <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      halt_cause    <= 2'd0;
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_next;
      last_pc       <= last_pc_next;
      loop_len      <= loop_len_next;
      loop_seen     <= loop_seen_next;
      core_rst      <= (state_next != ST_RUN);
      run_active    <= (state_next == ST_RUN);
      done          <= done_next;
      timeout       <= timeout_next;
      halt_cause    <= cause_next;
      cycle_count   <= cycle_next;
      retired_count <= retired_next;
    end
  end

  // Next-state and next-register logic. Halt priority is
  // ebreak > ecall > self-loop > timeout; counters include the
  // triggering cycle.
  always_comb begin
    state_next     = state;
    hold_next      = hold_cnt;
    last_pc_next   = last_pc;
    loop_len_next  = loop_len;
    loop_seen_next = loop_seen;
    done_next      = done;
    timeout_next   = timeout;
    cause_next     = halt_cause;
    cycle_next     = cycle_count;
    retired_next   = retired_count;
    cycle_inc      = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
    run_len        = 32'd1;
    loop_hit       = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next     = ST_RESET_HOLD;
          hold_next      = '0;
          last_pc_next   = '0;
          loop_len_next  = '0;
          loop_seen_next = 1'b0;
          done_next      = 1'b0;
          timeout_next   = 1'b0;
          cause_next     = 2'd0;
          cycle_next     = '0;
          retired_next   = '0;
        end
      end

      ST_RESET_HOLD: begin
        if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
          state_next = ST_RUN;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        cycle_next = cycle_inc;
        if (instr_valid) begin
          retired_next = (retired_count == '1) ? retired_count : retired_count + 1'b1;
          // An unchanged PC extends the run; the length saturates so a
          // disabled detector never wraps back into a false match.
          if (loop_seen && (pc == last_pc)) begin
            run_len = (loop_len == '1) ? loop_len : loop_len + 32'd1;
          end
          last_pc_next   = pc;
          loop_len_next  = run_len;
          loop_seen_next = 1'b1;
          loop_hit       = (LOOP_DETECT != 0) && (run_len >= 32'(LOOP_DETECT));
        end

        if (instr_valid && (instr == EBREAK)) begin
          cause_next = 2'd1;
          done_next  = 1'b1;
          state_next = ST_DONE;
        end else if (instr_valid && (instr == ECALL)) begin
          cause_next = 2'd2;
          done_next  = 1'b1;
          state_next = ST_DONE;
        end else if (loop_hit) begin
          cause_next = 2'd3;
          done_next  = 1'b1;
          state_next = ST_DONE;
        end else if (cycle_inc == CNT_W'(MAX_CYCLES)) begin
          timeout_next = 1'b1;
          done_next    = 1'b1;
          state_next   = ST_DONE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl
//   Self-checking bench for core_run_ctrl. Each run is described as a
//   per-RUN-cycle table of (pc, instr, valid); a reference model walks the
//   table applying the halt rules and predicts the halt cycle, cause and
//   counters. Directed tables cover the documented scenarios, followed by
//   randomized tables and an asynchronous mid-run reset.

module tb_core_run_ctrl;

  localparam int RST_CYCLES  = 2;
  localparam int MAX_CYCLES  = 7;
  localparam int LOOP_DETECT = 3;
  localparam int DEPTH       = 16;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] JSELF  = 32'h0000_006F;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        core_rst;
  logic        run_active;
  logic        done;
  logic        timeout;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;

  logic [31:0] stim_pc    [DEPTH];
  logic [31:0] stim_instr [DEPTH];
  logic        stim_valid [DEPTH];

  int checks_total;
  int checks_passed;

  core_run_ctrl #(
    .XLEN        (32),
    .RST_CYCLES  (RST_CYCLES),
    .MAX_CYCLES  (MAX_CYCLES),
    .LOOP_DETECT (LOOP_DETECT),
    .CNT_W       (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .core_rst      (core_rst),
    .run_active    (run_active),
    .done          (done),
    .timeout       (timeout),
    .halt_cause    (halt_cause),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Walk the table with the halt rules: returns the RUN cycle on which the
  // run ends, the counters at that point and the recorded status.
  task automatic modelRun(output int n, output int retired, output int cause,
                          output int tmo);
    int          run;
    logic        have_pc;
    logic [31:0] prev_pc;
    run = 0; have_pc = 1'b0; prev_pc = '0;
    n = 0; retired = 0; cause = 0; tmo = 0;
    for (int k = 0; k < DEPTH; k++) begin
      n++;
      if (stim_valid[k]) begin
        retired++;
        run = (have_pc && stim_pc[k] == prev_pc) ? run + 1 : 1;
        prev_pc = stim_pc[k];
        have_pc = 1'b1;
        if (stim_instr[k] == EBREAK)      cause = 1;
        else if (stim_instr[k] == ECALL)  cause = 2;
        else if (run >= LOOP_DETECT)      cause = 3;
      end
      if (cause != 0) return;
      if (n == MAX_CYCLES) begin
        tmo = 1;
        return;
      end
    end
  endtask

  task automatic fillStraight(input logic [31:0] base);
    for (int k = 0; k < DEPTH; k++) begin
      stim_pc[k]    = base + 32'(4 * k);
      stim_instr[k] = NOP;
      stim_valid[k] = 1'b1;
    end
  endtask

  task automatic fillRandom();
    logic [31:0] p;
    int          r;
    p = $urandom & 32'hFFFF_FFFC;
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0 && $urandom_range(0, 2) != 0) p = p + 32'd4;
      r = $urandom_range(0, 11);
      stim_pc[k]    = p;
      stim_instr[k] = (r == 0) ? EBREAK : (r == 1) ? ECALL : (r < 4) ? JSELF : NOP;
      stim_valid[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Start pulse from IDLE/DONE, then the reset hold with cleared status.
  task automatic pulseAndHold(input string name);
    start = 1'b1;
    stepClock();
    start = 1'b0;
    for (int i = 0; i < RST_CYCLES; i++) begin
      checkOutput({name, ".hold_core_rst"}, 32'(core_rst), 32'd1);
      checkOutput({name, ".hold_run_active"}, 32'(run_active), 32'd0);
      if (i == 0) begin
        checkOutput({name, ".clr_done"}, 32'(done), 32'd0);
        checkOutput({name, ".clr_timeout"}, 32'(timeout), 32'd0);
        checkOutput({name, ".clr_cause"}, 32'(halt_cause), 32'd0);
        checkOutput({name, ".clr_cycles"}, cycle_count, 32'd0);
        checkOutput({name, ".clr_retired"}, retired_count, 32'd0);
      end
      stepClock();
    end
    checkOutput({name, ".run_core_rst"}, 32'(core_rst), 32'd0);
    checkOutput({name, ".run_active"}, 32'(run_active), 32'd1);
  endtask

  // Run one table through the DUT; start_at >= 0 pulses start on that
  // RUN cycle, which must be ignored.
  task automatic applyStimulus(input string name, input int start_at);
    int n_exp, ret_exp, cause_exp, tmo_exp;
    int n_seen;
    logic [31:0] held;
    modelRun(n_exp, ret_exp, cause_exp, tmo_exp);
    pulseAndHold(name);
    n_seen = 0;
    for (int k = 0; k < DEPTH; k++) begin
      pc          = stim_pc[k];
      instr       = stim_instr[k];
      instr_valid = stim_valid[k];
      start       = (k == start_at);
      stepClock();
      start = 1'b0;
      n_seen++;
      if (done) break;
    end
    instr_valid = 1'b0;
    checkOutput({name, ".done"}, 32'(done), 32'd1);
    checkOutput({name, ".halt_cycle"}, 32'(n_seen), 32'(n_exp));
    checkOutput({name, ".cycle_count"}, cycle_count, 32'(n_exp));
    checkOutput({name, ".retired_count"}, retired_count, 32'(ret_exp));
    checkOutput({name, ".halt_cause"}, 32'(halt_cause), 32'(cause_exp));
    checkOutput({name, ".timeout"}, 32'(timeout), 32'(tmo_exp));
    checkOutput({name, ".done_core_rst"}, 32'(core_rst), 32'd1);
    checkOutput({name, ".done_run_active"}, 32'(run_active), 32'd0);
    // DONE holds everything even with valid traffic on the bus.
    held = cycle_count;
    instr_valid = 1'b1;
    instr       = EBREAK;
    stepClock();
    stepClock();
    instr_valid = 1'b0;
    checkOutput({name, ".hold_cycles"}, cycle_count, held);
    checkOutput({name, ".hold_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst         = 1'b0;
    start       = 1'b0;
    pc          = '0;
    instr       = NOP;
    instr_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.core_rst", 32'(core_rst), 32'd1);
    checkOutput("reset.run_active", 32'(run_active), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.cycle_count", cycle_count, 32'd0);
    rst = 1'b1;
    stepClock();

    // Directed scenarios.
    fillStraight(32'h0000_1000);
    applyStimulus("timeout", -1);

    fillStraight(32'h0000_2000);
    stim_instr[2] = EBREAK;
    applyStimulus("ebreak3", -1);

    for (int k = 0; k < DEPTH; k++) begin
      stim_pc[k] = 32'h0000_0010; stim_instr[k] = JSELF; stim_valid[k] = 1'b1;
    end
    applyStimulus("selfloop", -1);
    stim_valid[1] = 1'b0;
    applyStimulus("selfloop_gap", -1);

    fillStraight(32'h0000_3000);
    stim_instr[MAX_CYCLES-1] = ECALL;
    applyStimulus("ecall_vs_timeout", -1);

    fillStraight(32'h0000_4000);
    applyStimulus("start_in_run", 2);
    applyStimulus("restart", -1);

    // Randomized tables.
    for (int t = 0; t < 24; t++) begin
      fillRandom();
      applyStimulus($sformatf("rand%0d", t), ($urandom_range(0, 1) == 1) ? 0 : -1);
    end

    // Asynchronous reset mid-RUN, between clock edges.
    fillStraight(32'h0000_5000);
    pulseAndHold("async");
    pc = stim_pc[0]; instr = NOP; instr_valid = 1'b1;
    stepClock();
    stepClock();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async.core_rst", 32'(core_rst), 32'd1);
    checkOutput("async.run_active", 32'(run_active), 32'd0);
    checkOutput("async.done", 32'(done), 32'd0);
    checkOutput("async.cycle_count", cycle_count, 32'd0);
    checkOutput("async.retired_count", retired_count, 32'd0);
    #1;
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (3) stepClock();
    checkOutput("async.idle_core_rst", 32'(core_rst), 32'd1);
    checkOutput("async.idle_active", 32'(run_active), 32'd0);
    checkOutput("async.idle_cycles", cycle_count, 32'd0);

    fillStraight(32'h0000_6000);
    stim_instr[4] = ECALL;
    applyStimulus("after_reset", -1);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Synthesizable run controller for the single-cycle RV32 core (TOP).
- Generates the core's reset sequence and bounds the run length.
- Watches the core's fetch stream for halt conditions: ebreak, ecall, self-loop or cycle timeout.
- Reports status and counters. Used in both the bench and FPGA bring-up, replacing a hard-coded reset/run timing.

Parameters:
- XLEN, 32, width of the PC input.
- RST_CYCLES, 2, cycles core_rst is held high after start; legal range is 1 or more.
- MAX_CYCLES, 7, run cycles before timeout; legal range is 1 or more.
- LOOP_DETECT, 3, consecutive valid cycles at an unchanged PC that count as a self-loop halt; 0 disables the check.
- CNT_W, 32, width of the counters.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst, in, 1, asynchronous, active-low reset of this block.
- start, in, 1, single-cycle pulse that begins a run. Only honoured in IDLE or DONE.
- pc, in, XLEN, current PC of the core.
- instr, in, 32, current fetched instruction.
- instr_valid, in, 1, pc/instr valid this cycle. Only sampled in RUN.
- core_rst, out, 1, active-high reset driven to TOP.
- run_active, out, 1, high while in RUN.
- done, out, 1, sticky run-complete flag.
- timeout, out, 1, sticky: the run ended by reaching MAX_CYCLES.
- halt_cause, out, 2, 0 none, 1 ebreak, 2 ecall, 3 self-loop.
- cycle_count, out, CNT_W, cycles spent in RUN.
- retired_count, out, CNT_W, RUN cycles with instr_valid high.

Behaviour:
- States: IDLE, RESET_HOLD, RUN, DONE. All outputs are registered.
- rst low, at any time and asynchronously:
  - state goes to IDLE; core_rst=1.
  - run_active, done, timeout = 0; halt_cause = 0; both counters = 0; loop tracker cleared.
- IDLE: core_rst=1. start=1 moves to RESET_HOLD. On the same edge, clear done, timeout, halt_cause, both counters and the loop tracker.
- RESET_HOLD:
  - core_rst=1 for exactly RST_CYCLES cycles, counted by an internal hold counter.
  - On the edge ending the last hold cycle, move to RUN; core_rst=0 and run_active=1 from that edge.
- RUN, every cycle:
  - cycle_count increments.
  - retired_count increments if instr_valid.
  - Both counters saturate at all-ones; no wrap.
- Halt checks are evaluated only when instr_valid=1:
  - ebreak: instr == 32'h0010_0073.
  - ecall: instr == 32'h0000_0073.
  - self-loop: pc equals the pc of the previous valid cycle for LOOP_DETECT consecutive valid cycles, counting the first. An invalid cycle holds the tracker; a pc change resets the run length to 1. Example: jal x0,0 = 32'h0000_006F.
- Timeout: the post-increment cycle_count equals MAX_CYCLES.
- Simultaneous events, priority: ebreak > ecall > self-loop > timeout.
  - A halt_cause always wins; timeout=1 only if no halt_cause fired in that cycle.
- On the triggering edge:
  - move to DONE; record halt_cause or timeout.
  - the counters include the triggering cycle.
  - done=1, run_active=0 and core_rst=1 become visible the next cycle (one-cycle latency from the triggering cycle).
- DONE:
  - core_rst=1; done, status and counters hold.
  - start=1 re-enters RESET_HOLD with the same clears as from IDLE.
- start in RESET_HOLD or RUN is ignored; no restart and no counter clear.
- rst asserted mid-RUN: immediate IDLE and core_rst=1; no status is retained.

Test Plan:
- Defaults, start pulse at cycle 0:
  - core_rst=1 for 2 cycles, then 0.
  - With instr=NOP (32'h0000_0013), pc stepping by 4, valid every cycle: after 7 RUN cycles, done=1, timeout=1, halt_cause=0, cycle_count=7, retired_count=7.
- instr=32'h0010_0073 on the 3rd valid RUN cycle -> done=1, halt_cause=1, timeout=0, cycle_count=3; core_rst=1 the following cycle.
- pc held at 0x0000_0010 with instr=32'h0000_006F for 3 valid cycles -> halt_cause=3, cycle_count=3.
  - Same stimulus with instr_valid low on the middle cycle -> halt on the 4th RUN cycle, retired_count=3.
- ecall on RUN cycle 7, coinciding with timeout -> halt_cause=2, timeout=0, cycle_count=7.
- start pulsed during RUN -> ignored; counters are not cleared.
  - After done, a new start clears done, timeout, halt_cause and both counters and repeats the 2-cycle reset hold.
- rst driven low mid-RUN, between clock edges -> core_rst=1, done=0 and counters=0 immediately, without waiting for a clock edge; state is IDLE after rst returns high.
